shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine.sv | 87 ++++++++
 tb/tb_shift_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine with a legacy single-step serial right shift.
// Three-state FSM: IDLE accepts Load/Start/Shift_En, SHIFT steps once per cycle, DONE pulses for one cycle.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Start,
  input  logic [CNT_W-1:0] Amount,
  input  logic [1:0]       Mode,
  input  logic             Shift_En,
  input  logic             Shift_In,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [1:0] m);
    case (m)
      2'b00:   step = {1'b0, v[WIDTH-1:1]};
      2'b01:   step = {v[WIDTH-2:0], 1'b0};
      2'b10:   step = {v[0], v[WIDTH-1:1]};
      default: step = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (Load) begin
          data_d = D;
        end else if (Start) begin
          mode_d  = Mode;
          cnt_d   = (Amount > WIDTH_C) ? WIDTH_C : Amount;
          state_d = (cnt_d == '0) ? DONE : SHIFT;
        end else if (Shift_En) begin
          data_d = {Shift_In, data_q[WIDTH-1:1]};
        end
      end
      SHIFT: begin
        data_d = step(data_q, mode_q);
        cnt_d  = cnt_q - CNT_W'(1);
        // cnt_q of 0 is unreachable here; treat it as last step so the FSM can never stick
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Data_Out  = data_q;
  assign Shift_Out = data_q[0];
  assign Busy      = (state_q == SHIFT);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine (WIDTH=8): a behavioural model computes each cycle's expected outputs
// from the start value and step count; literal expectations pin the key scenarios.
module tb_shift_engine;
  localparam int W = 8;
  localparam int CW = $clog2(W) + 1;

  logic          Clk = 1'b0;
  logic          Reset, Load, Start, Shift_En, Shift_In;
  logic [W-1:0]  D;
  logic [CW-1:0] Amount;
  logic [1:0]    Mode;
  logic [W-1:0]  Data_Out;
  logic          Shift_Out, Busy, Done;

  int checks = 0;
  int errors = 0;

  shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Start(Start), .Amount(Amount),
    .Mode(Mode), .Shift_En(Shift_En), .Shift_In(Shift_In), .Data_Out(Data_Out),
    .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Model: value after k steps is computed directly from the start value.
  logic [W-1:0] m_val, m_v0;
  logic [1:0]   m_mode;
  int           m_n, m_k;
  bit           m_act, m_done;

  function automatic logic [W-1:0] shifted(input logic [W-1:0] v, input logic [1:0] m, input int k);
    logic [2*W-1:0] dbl;
    dbl = {v, v} >> k;
    case (m)
      2'b00:   shifted = v >> k;
      2'b01:   shifted = W'(v << k);
      2'b10:   shifted = dbl[W-1:0];
      default: shifted = W'($signed(v) >>> k);
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_val = '0; m_act = 0; m_done = 0; m_mode = 2'b00; m_n = 0; m_k = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_act) begin
      m_k++;
      m_val = shifted(m_v0, m_mode, m_k);
      if (m_k >= m_n) begin m_act = 0; m_done = 1; end
    end else if (Load) begin
      m_val = D;
    end else if (Start) begin
      m_n = (int'(Amount) > W) ? W : int'(Amount);
      m_mode = Mode; m_v0 = m_val; m_k = 0;
      if (m_n == 0) m_done = 1; else m_act = 1;
    end else if (Shift_En) begin
      m_val = {Shift_In, m_val[W-1:1]};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs against the model.
  task automatic tick();
    @(negedge Clk);
    if (!Reset) begin
      chk("model Data_Out", 64'(Data_Out), 64'(m_val));
      chk("model Shift_Out", 64'(Shift_Out), 64'(m_val[0]));
      chk("model Busy", 64'(Busy), 64'(m_act));
      chk("model Done", 64'(Done), 64'(m_done));
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    Load = 1; D = v; tick(); Load = 0;
  endtask

  task automatic do_op(input string name, input logic [1:0] m, input logic [CW-1:0] amt, input bit disturb,
                       input logic [W-1:0] exp_val, input int exp_busy);
    int busy_cnt = 0;
    bit seen = 0;
    Start = 1; Mode = m; Amount = amt; tick(); Start = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1; break; end
      if (Busy) busy_cnt++;
      if (disturb) begin
        Load = 1; D = 8'hFF; Start = 1; Mode = ~m; Amount = 1; Shift_En = 1; Shift_In = 1;
      end
      tick();
    end
    Load = 0; Start = 0; Shift_En = 0; Shift_In = 0;
    chk({name, " done seen"}, 64'(seen), 64'd1);
    chk({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_busy));
    chk({name, " result"}, 64'(Data_Out), 64'(exp_val));
    tick();
    chk({name, " done one cycle"}, 64'(Done), 64'd0);
  endtask

  initial begin
    int done_cnt;
    Reset = 1; Load = 0; Start = 0; Shift_En = 0; Shift_In = 0; D = '0; Amount = '0; Mode = 2'b00;
    #1;
    chk("reset Data_Out", 64'(Data_Out), 64'd0);
    chk("reset Busy", 64'(Busy), 64'd0);
    chk("reset Done", 64'(Done), 64'd0);
    chk("reset Shift_Out", 64'(Shift_Out), 64'd0);
    @(negedge Clk); @(negedge Clk);
    Reset = 0;
    tick();

    load(8'hB5);
    do_op("lsr3", 2'b00, 3, 0, 8'h16, 3);
    load(8'h96);
    do_op("asr2", 2'b11, 2, 0, 8'hE5, 2);
    load(8'h96);
    do_op("ror4", 2'b10, 4, 0, 8'h69, 4);
    load(8'h81);
    do_op("lsl0", 2'b01, 0, 0, 8'h81, 0);
    do_op("ror12 clamp", 2'b10, 12, 0, 8'h81, 8);
    load(8'h81);
    do_op("lsl3", 2'b01, 3, 0, 8'h08, 3);
    load(8'h81);
    do_op("lsl9 clamp", 2'b01, 9, 0, 8'h00, 8);

    // Load wins over Start; no operation is started.
    Load = 1; D = 8'h3C; Start = 1; Mode = 2'b01; Amount = 3; tick();
    Load = 0; Start = 0;
    chk("load+start Data_Out", 64'(Data_Out), 64'h3C);
    chk("load+start Busy", 64'(Busy), 64'd0);
    tick();
    chk("load+start no Done", 64'(Done), 64'd0);

    // Inputs toggled during SHIFT must not change the result.
    load(8'hB5);
    do_op("lsr3 disturbed", 2'b00, 3, 1, 8'h16, 3);
    load(8'h96);
    do_op("asr5 disturbed", 2'b11, 5, 1, 8'hFC, 5);

    // Legacy serial step.
    load(8'h01);
    chk("serial Shift_Out before", 64'(Shift_Out), 64'd1);
    Shift_En = 1; Shift_In = 1; tick(); Shift_En = 0; Shift_In = 0;
    chk("serial Data_Out", 64'(Data_Out), 64'h80);
    chk("serial Shift_Out after", 64'(Shift_Out), 64'd0);

    // Asynchronous reset in the middle of a shift.
    load(8'hB5);
    Start = 1; Mode = 2'b00; Amount = 5; tick(); Start = 0;
    tick();
    chk("pre-reset Busy", 64'(Busy), 64'd1);
    #2 Reset = 1;
    #1;
    chk("async reset Data_Out", 64'(Data_Out), 64'd0);
    chk("async reset Busy", 64'(Busy), 64'd0);
    chk("async reset Done", 64'(Done), 64'd0);
    @(negedge Clk);
    Reset = 0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Done) done_cnt++;
    end
    chk("no Done after reset", 64'(done_cnt), 64'd0);
    chk("post-reset Data_Out", 64'(Data_Out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
